// File: rtl/multicycle_alu.sv
// multicycle_alu: single-cycle logic/arithmetic/shift ops with a registered
// result, plus iterative signed/unsigned multiply and divide into HI/LO.
module multicycle_alu #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [5:0]       Signal,
  input  logic [WIDTH-1:0] dataA,
  input  logic [WIDTH-1:0] dataB,
  output logic [WIDTH-1:0] Output,
  output logic             out_valid,
  output logic             busy,
  output logic             md_done,
  output logic             div_zero
);

  typedef enum logic [5:0] {
    OP_SLL   = 6'd0,
    OP_SRL   = 6'd2,
    OP_MFHI  = 6'd16,
    OP_MFLO  = 6'd18,
    OP_MULT  = 6'd24,
    OP_MULTU = 6'd25,
    OP_DIV   = 6'd26,
    OP_DIVU  = 6'd27,
    OP_ADD   = 6'd32,
    OP_SUB   = 6'd34,
    OP_AND   = 6'd36,
    OP_OR    = 6'd37,
    OP_SLT   = 6'd42
  } op_e;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_RUN  = 1'b1
  } state_e;

  localparam logic [SHW-1:0] LAST = SHW'(WIDTH - 1);

  state_e           r_state;
  logic             r_busy;
  logic [SHW-1:0]   r_cnt;
  logic             r_is_div;
  logic             r_neg_q;
  logic             r_neg_r;
  logic             r_dz;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_acc;
  logic [WIDTH-1:0] r_q;
  logic [WIDTH-1:0] r_hi;
  logic [WIDTH-1:0] r_lo;
  logic [WIDTH-1:0] r_out;
  logic             r_ov;
  logic             r_md;
  logic             r_dzf;

  logic             w_accept;
  logic             w_is_md;
  logic             w_signed;
  logic [WIDTH-1:0] w_abs_a;
  logic [WIDTH-1:0] w_abs_b;
  logic [WIDTH-1:0] w_alu;
  logic [WIDTH:0]   w_msum;
  logic [WIDTH:0]   w_dshift;
  logic             w_dge;
  logic [WIDTH-1:0] w_ddiff;
  logic [WIDTH-1:0] w_acc_nx;
  logic [WIDTH-1:0] w_q_nx;
  logic [2*WIDTH-1:0] w_prod;
  logic [WIDTH-1:0] w_hi_fin;
  logic [WIDTH-1:0] w_lo_fin;

  assign in_ready  = ~r_busy;
  assign busy      = r_busy;
  assign Output    = r_out;
  assign out_valid = r_ov;
  assign md_done   = r_md;
  assign div_zero  = r_dzf;

  assign w_accept = in_valid & ~r_busy;
  assign w_is_md  = (Signal[5:2] == 4'b0110);
  // MULT and DIV are the even codes of the 24..27 group
  assign w_signed = ~Signal[0];
  assign w_abs_a  = (w_signed && dataA[WIDTH-1]) ? -dataA : dataA;
  assign w_abs_b  = (w_signed && dataB[WIDTH-1]) ? -dataB : dataB;

  // Single-cycle result selection
  always_comb begin
    w_alu = '0;
    case (Signal)
      OP_AND:  w_alu = dataA & dataB;
      OP_OR:   w_alu = dataA | dataB;
      OP_ADD:  w_alu = dataA + dataB;
      OP_SUB:  w_alu = dataA - dataB;
      OP_SLT:  w_alu = {{(WIDTH-1){1'b0}}, ($signed(dataA) < $signed(dataB))};
      OP_SLL:  w_alu = dataA << dataB[SHW-1:0];
      OP_SRL:  w_alu = dataA >> dataB[SHW-1:0];
      OP_MFHI: w_alu = r_hi;
      OP_MFLO: w_alu = r_lo;
      default: w_alu = '0;
    endcase
  end

  // One multiply (shift-add) or divide (restoring) iteration, plus final sign fix-up
  always_comb begin
    w_msum   = {1'b0, r_acc} + (r_q[0] ? {1'b0, r_b} : '0);
    w_dshift = {r_acc, r_q[WIDTH-1]};
    w_dge    = (w_dshift >= {1'b0, r_b});
    // remainder stays below the divisor, so the low WIDTH bits suffice
    w_ddiff  = w_dshift[WIDTH-1:0] - r_b;
    if (r_is_div) begin
      w_acc_nx = w_dge ? w_ddiff : w_dshift[WIDTH-1:0];
      w_q_nx   = {r_q[WIDTH-2:0], w_dge};
    end else begin
      w_acc_nx = w_msum[WIDTH:1];
      w_q_nx   = {w_msum[0], r_q[WIDTH-1:1]};
    end
    w_prod = {w_acc_nx, w_q_nx};
    if (r_neg_q)
      w_prod = -w_prod;
    if (r_is_div) begin
      if (r_dz) begin
        w_lo_fin = '1;
        w_hi_fin = r_a;
      end else begin
        w_lo_fin = r_neg_q ? -w_q_nx : w_q_nx;
        w_hi_fin = r_neg_r ? -w_acc_nx : w_acc_nx;
      end
    end else begin
      w_hi_fin = w_prod[2*WIDTH-1:WIDTH];
      w_lo_fin = w_prod[WIDTH-1:0];
    end
  end

  // Issue, iteration FSM and all registered outputs
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state  <= S_IDLE;
      r_busy   <= 1'b0;
      r_cnt    <= '0;
      r_is_div <= 1'b0;
      r_neg_q  <= 1'b0;
      r_neg_r  <= 1'b0;
      r_dz     <= 1'b0;
      r_a      <= '0;
      r_b      <= '0;
      r_acc    <= '0;
      r_q      <= '0;
      r_hi     <= '0;
      r_lo     <= '0;
      r_out    <= '0;
      r_ov     <= 1'b0;
      r_md     <= 1'b0;
      r_dzf    <= 1'b0;
    end else begin
      r_ov <= 1'b0;
      r_md <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            if (w_is_md) begin
              r_state  <= S_RUN;
              r_busy   <= 1'b1;
              r_cnt    <= '0;
              r_is_div <= Signal[1];
              r_neg_q  <= w_signed & (dataA[WIDTH-1] ^ dataB[WIDTH-1]);
              r_neg_r  <= w_signed & dataA[WIDTH-1];
              r_dz     <= Signal[1] & (dataB == '0);
              r_a      <= dataA;
              r_b      <= w_abs_b;
              r_acc    <= '0;
              r_q      <= w_abs_a;
              if (Signal[1])
                r_dzf <= (dataB == '0);
            end else begin
              r_out <= w_alu;
              r_ov  <= 1'b1;
            end
          end
        end
        S_RUN: begin
          r_acc <= w_acc_nx;
          r_q   <= w_q_nx;
          r_cnt <= r_cnt + 1'b1;
          if (r_cnt == LAST) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
            r_md    <= 1'b1;
            r_hi    <= w_hi_fin;
            r_lo    <= w_lo_fin;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_multicycle_alu.sv
// Directed testbench for multicycle_alu at WIDTH=32.
module tb_multicycle_alu;

  logic        clk;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [5:0]  Signal;
  logic [31:0] dataA;
  logic [31:0] dataB;
  logic [31:0] Output;
  logic        out_valid;
  logic        busy;
  logic        md_done;
  logic        div_zero;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  multicycle_alu #(.WIDTH(32)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .Signal(Signal), .dataA(dataA), .dataB(dataB), .Output(Output),
    .out_valid(out_valid), .busy(busy), .md_done(md_done), .div_zero(div_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Issue one single-cycle op and check result, pulse and pulse width
  task automatic single(input string tag, input logic [5:0] sig,
                        input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp);
    @(negedge clk);
    Signal = sig; dataA = a; dataB = b; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    check({tag, "_valid"}, {31'd0, out_valid}, 32'd1);
    check(tag, Output, exp);
    @(posedge clk); #1;
    check({tag, "_pulse"}, {31'd0, out_valid}, 32'd0);
  endtask

  // Issue a multi-cycle op and follow it to completion; then read HI/LO
  task automatic md(input string tag, input logic [5:0] sig,
                    input logic [31:0] a, input logic [31:0] b,
                    input logic [31:0] exp_hi, input logic [31:0] exp_lo);
    int unsigned n;
    int unsigned bad;
    @(negedge clk);
    Signal = sig; dataA = a; dataB = b; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    n = 0; bad = 0;
    while (busy && n < 100) begin
      if (in_ready || md_done || out_valid) bad++;
      @(posedge clk); #1;
      n++;
    end
    check({tag, "_busycycles"}, n, 32'd32);
    check({tag, "_hsk"}, bad, 32'd0);
    check({tag, "_md_done"}, {31'd0, md_done}, 32'd1);
    single({tag, "_hi"}, 6'd16, 32'd0, 32'd0, exp_hi);
    single({tag, "_lo"}, 6'd18, 32'd0, 32'd0, exp_lo);
  endtask

  initial begin
    int unsigned n;
    int unsigned ov_seen;
    reset = 1'b0; in_valid = 1'b0; Signal = '0; dataA = '0; dataB = '0;
    #12;
    check("rst_out", Output, 32'd0);
    check("rst_ov", {31'd0, out_valid}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_ready", {31'd0, in_ready}, 32'd1);
    check("rst_dz", {31'd0, div_zero}, 32'd0);
    @(negedge clk); reset = 1'b1;

    single("add", 6'd32, 32'h7FFF_FFFF, 32'd1, 32'h8000_0000);
    single("sub", 6'd34, 32'd0, 32'd1, 32'hFFFF_FFFF);
    single("slt", 6'd42, 32'hFFFF_FFFF, 32'd1, 32'd1);
    single("slt0", 6'd42, 32'd1, 32'hFFFF_FFFF, 32'd0);
    single("srl", 6'd2, 32'h8000_0000, 32'd31, 32'd1);
    single("sll", 6'd0, 32'h0000_0003, 32'h0000_0024, 32'h0000_0030);
    single("and", 6'd36, 32'hF0F0_1234, 32'h0FF0_FF00, 32'h00F0_1200);
    single("or", 6'd37, 32'hF000_0001, 32'h0000_1000, 32'hF000_1001);
    single("bad", 6'd63, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0);

    md("multu", 6'd25, 32'hFFFF_FFFF, 32'd2, 32'd1, 32'hFFFF_FFFE);
    md("mult", 6'd24, 32'hFFFF_FFFD, 32'd5, 32'hFFFF_FFFF, 32'hFFFF_FFF1);
    md("div", 6'd26, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
    md("divmin", 6'd26, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'h8000_0000);
    check("divmin_dz", {31'd0, div_zero}, 32'd0);
    md("divu", 6'd27, 32'd100, 32'd7, 32'd2, 32'd14);
    check("divu_dz", {31'd0, div_zero}, 32'd0);
    md("divu0", 6'd27, 32'd9, 32'd0, 32'd9, 32'hFFFF_FFFF);
    check("divu0_dz", {31'd0, div_zero}, 32'd1);
    single("add_dz", 6'd32, 32'd1, 32'd2, 32'd3);
    check("dz_sticky", {31'd0, div_zero}, 32'd1);
    md("divu8", 6'd27, 32'd8, 32'd2, 32'd0, 32'd4);
    check("dz_clear", {31'd0, div_zero}, 32'd0);

    // ADD held on in_valid through a DIVU; accepted in the md_done cycle
    @(negedge clk);
    Signal = 6'd27; dataA = 32'd50; dataB = 32'd5; in_valid = 1'b1;
    @(posedge clk); #1;
    Signal = 6'd32; dataA = 32'd3; dataB = 32'd4;
    n = 0; ov_seen = 0;
    while (busy && n < 100) begin
      if (out_valid) ov_seen++;
      @(posedge clk); #1;
      n++;
    end
    check("hold_busycycles", n, 32'd32);
    check("hold_no_ov", ov_seen, 32'd0);
    check("hold_md_done", {31'd0, md_done}, 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    check("hold_add_ov", {31'd0, out_valid}, 32'd1);
    check("hold_add", Output, 32'd7);
    single("hold_lo", 6'd18, 32'd0, 32'd0, 32'd10);

    // Reset in the middle of a MULTU
    @(negedge clk);
    Signal = 6'd25; dataA = 32'h1234_5678; dataB = 32'd3; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (10) @(posedge clk);
    #2 reset = 1'b0;
    #1;
    check("abort_busy", {31'd0, busy}, 32'd0);
    check("abort_ready", {31'd0, in_ready}, 32'd1);
    check("abort_out", Output, 32'd0);
    @(negedge clk); reset = 1'b1;
    repeat (40) @(posedge clk);
    #1 check("abort_no_done", {31'd0, md_done}, 32'd0);
    single("abort_lo", 6'd18, 32'd0, 32'd0, 32'd0);
    single("abort_hi", 6'd16, 32'd0, 32'd0, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
